// File: rtl/request_unit.sv
// request_unit: fetch/execute/memory request sequencer with sticky halt.
// Optional stall_cnt port and logic are built only when REQUEST_UNIT_STALL_CNT_EN is defined.
module request_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        dhit,
    input  logic        cu_dREN,
    input  logic        cu_dWEN,
    input  logic        cu_halt,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        pc_en,
    output logic [31:0] instr,
    output logic        halt
`ifdef REQUEST_UNIT_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {IFETCH, EXEC, DMEM, HALTED} state_t;
    state_t      state;
    logic        rd_q, wr_q;
    logic [31:0] instr_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IFETCH;
            instr_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state)
                IFETCH: if (ihit) begin
                    instr_q <= imemload;
                    state   <= EXEC;
                end
                EXEC: if (cu_halt) state <= HALTED;
                else if (cu_dREN || cu_dWEN) begin
                    // a simultaneous read and write request is treated as a store
                    rd_q  <= cu_dREN && !cu_dWEN;
                    wr_q  <= cu_dWEN;
                    state <= DMEM;
                end else state <= IFETCH;
                DMEM: if (dhit) begin
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    state <= IFETCH;
                end
                default: ;
            endcase
        end
    end
    // every output is forced low while reset is held
    assign imemREN = !RST && state == IFETCH;
    assign dmemREN = !RST && state == DMEM && rd_q;
    assign dmemWEN = !RST && state == DMEM && wr_q;
    assign pc_en   = !RST && ((state == EXEC && !cu_halt && !cu_dREN && !cu_dWEN) || (state == DMEM && dhit));
    assign instr   = RST ? '0 : instr_q;
    assign halt    = !RST && state == HALTED;
`ifdef REQUEST_UNIT_STALL_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else if (((state == IFETCH && !ihit) || (state == DMEM && !dhit)) && cnt_q != 32'hFFFF_FFFF)
            cnt_q <= cnt_q + 32'd1;
    end
    assign stall_cnt = RST ? '0 : cnt_q;
`endif
endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are listed below, one per line, clock and reset first.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 ihit  input  1  instruction memory ack; imemload valid this cycle.
REQ-005 imemload  input  32  instruction word from instruction memory.
REQ-006 dhit  input  1  data memory ack for the current load/store.
REQ-007 cu_dREN  input  1  control unit load request for the decoded instr.
REQ-008 cu_dWEN  input  1  control unit store request for the decoded instr.
REQ-009 cu_halt  input  1  control unit halt for the decoded instr.
REQ-010 imemREN  output  1  instruction fetch request.
REQ-011 dmemREN  output  1  data read request.
REQ-012 dmemWEN  output  1  data write request.
REQ-013 pc_en  output  1  one-cycle PC advance strobe.
REQ-014 instr  output  32  registered instruction; opcode and funct fields drive the control unit.
REQ-015 halt  output  1  sticky halted flag.
REQ-016 stall_cnt  output  32  memory-wait cycle count; present only with REQUEST_UNIT_STALL_CNT_EN.

Function
REQ-017 SHALL implement a 4-state FSM: IFETCH, EXEC, DMEM, HALTED.
REQ-018 IFETCH: imemREN=1. On ihit, instr<=imemload and next state EXEC. Otherwise hold.
REQ-019 EXEC: imemREN=dmemREN=dmemWEN=0. Decoded cu_* inputs are sampled this cycle only.
REQ-020 EXEC, cu_halt=1: next state HALTED, pc_en=0. Halt has priority over dREN/dWEN.
REQ-021 EXEC, cu_halt=0, cu_dREN or cu_dWEN set: latch the request into rd_q/wr_q and go to DMEM, pc_en=0.
REQ-022 EXEC, no halt and no memory request: pc_en=1 for this cycle, next state IFETCH.
REQ-023 DMEM: dmemREN=rd_q and dmemWEN=wr_q. These come from the latched copies, stable across the whole wait.
REQ-024 DMEM, dhit=1: pc_en=1 this cycle, both requests drop next cycle, next state IFETCH. No dhit: hold.
REQ-025 If cu_dREN and cu_dWEN are both 1 in EXEC, SHALL treat the instr as a store: wr_q=1, rd_q=0.
REQ-026 ihit outside IFETCH and dhit outside DMEM SHALL be ignored, with no state or instr change.
REQ-027 imemREN, dmemREN and dmemWEN SHALL never be asserted in the same cycle.
REQ-028 pc_en SHALL be high for exactly one cycle per retired instruction and never in IFETCH or HALTED.
REQ-029 Latency, ALU instr with ihit in the first fetch cycle: pc_en 1 cycle later. Load/store with immediate dhit: pc_en 2 cycles after ihit.
REQ-030 HALTED: all requests 0, pc_en 0, halt=1. Only RST exits this state.

Reset
REQ-031 RST=1 at a clock edge SHALL set state=IFETCH, instr=0, rd_q=wr_q=0, halt=0 and stall_cnt=0, from any state including mid-DMEM wait.
REQ-032 While RST=1, all outputs SHALL be driven 0: imemREN is gated by !RST. The first fetch request appears in the first cycle RST is low.

Configuration
REQ-033 Macro REQUEST_UNIT_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle in IFETCH with ihit=0 or in DMEM with dhit=0.
REQ-034 The counter saturates at 0xFFFFFFFF, is frozen in HALTED, and is cleared only by RST.
REQ-035 Macro undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-036 Bench SHALL cover: RST for 2 cycles, then ihit=1 with imemload=0x00221820 (add) and no cu requests. Required: instr=0x00221820, and pc_en pulses exactly once, 1 cycle after ihit.
REQ-037 Bench SHALL cover: load (cu_dREN=1) with dhit delayed 3 cycles. Required: dmemREN high for 4 cycles and imemREN low throughout; pc_en on the dhit cycle; stall_cnt=3 if enabled.
REQ-038 Bench SHALL cover: cu_dREN=cu_dWEN=1 in EXEC. Required: dmemWEN=1 and dmemREN=0 throughout DMEM.
REQ-039 Bench SHALL cover: cu_halt=1 together with cu_dWEN=1. Required: halt=1 next cycle with no dmemWEN ever; stray ihit/dhit pulses cause no change until RST.
REQ-040 Bench SHALL cover: RST asserted in cycle 2 of a DMEM wait. Required: the next cycle has all outputs 0, halt=0 and instr=0; after release, imemREN=1 in the first cycle.
REQ-041 Bench SHALL cover: ihit asserted while in EXEC with imemload=0xFFFFFFFF. Required: instr unchanged.
